// File: rtl/rv32i_pkg.sv
// Shared constants for the rv32i core-local interrupt logic: timer widths,
// mtimecmp reset value and the mcause codes the CLINT outputs map onto.
package rv32i_pkg;

    localparam int MTIME_W = 64;
    localparam int PRESC_W = 10;

    localparam logic [MTIME_W-1:0] MTIMECMP_RST_DFLT = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic MCAUSE_INTR_BIT = 1'b1;

    typedef enum logic [3:0] {
        MCAUSE_SW    = 4'd3,
        MCAUSE_TIMER = 4'd7,
        MCAUSE_EXT   = 4'd11
    } irq_cause_e;

    // Full 32-bit mcause value the trap logic writes for a given interrupt source.
    function automatic logic [31:0] mcause_code(irq_cause_e cause);
        return {MCAUSE_INTR_BIT, 27'd0, cause};
    endfunction

endpackage

// File: rtl/rv32i_irq_sync.sv
// Two-flop synchronizer for an asynchronous interrupt line with a
// rising-edge detector on the synchronized output.
module rv32i_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out   = sync_q;
    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/rv32i_clint.sv
// Core-local interruptor: microsecond mtime/mtimecmp timer, software
// interrupt bit and a latched, synchronized external interrupt.
module rv32i_clint
    import rv32i_pkg::*;
#(
    parameter int                 CLK_FREQ_MHZ = 100,
    parameter logic [MTIME_W-1:0] MTIMECMP_RST = MTIMECMP_RST_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mtime_wr,
    input  logic               mtimecmp_wr,
    input  logic [MTIME_W-1:0] mtime_din,
    input  logic [MTIME_W-1:0] mtimecmp_din,
    input  logic               msip_set,
    input  logic               msip_clr,
    input  logic               ext_irq_in,
    input  logic               ext_ack,
    output logic [MTIME_W-1:0] mtime,
    output logic [MTIME_W-1:0] mtimecmp,
    output logic               tick_1us,
    output logic               timer_interrupt,
    output logic               software_interrupt,
    output logic               external_interrupt
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_MHZ - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MTIME_W-1:0] mtime_q, mtime_d;
    logic [MTIME_W-1:0] mtimecmp_q, mtimecmp_d;
    logic               tick_q, tick_d;
    logic               timer_q, timer_d;
    logic               msip_q, msip_d;
    logic               ext_pend_q, ext_pend_d;
    logic               wrap;
    logic               ext_rise;
    logic               ext_sync_unused;

    rv32i_irq_sync u_ext_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (ext_irq_in),
        .sync_out   (ext_sync_unused),
        .rise_pulse (ext_rise)
    );

    // A software write to mtime restarts the microsecond period and
    // swallows any tick that would have landed on the same edge.
    always_comb begin
        wrap       = (presc_q == PRESC_MAX);
        presc_d    = (mtime_wr || wrap) ? '0 : presc_q + PRESC_W'(1);
        tick_d     = wrap && !mtime_wr;
        mtime_d    = mtime_wr ? mtime_din : (wrap ? mtime_q + 64'd1 : mtime_q);
        mtimecmp_d = mtimecmp_wr ? mtimecmp_din : mtimecmp_q;
        timer_d    = (mtime_d >= mtimecmp_d);
        msip_d     = msip_set ? 1'b1 : (msip_clr ? 1'b0 : msip_q);
        ext_pend_d = ext_rise ? 1'b1 : (ext_ack ? 1'b0 : ext_pend_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            tick_q     <= 1'b0;
            timer_q    <= 1'b0;
            msip_q     <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            tick_q     <= tick_d;
            timer_q    <= timer_d;
            msip_q     <= msip_d;
            ext_pend_q <= ext_pend_d;
        end
    end

    assign mtime              = mtime_q;
    assign mtimecmp           = mtimecmp_q;
    assign tick_1us           = tick_q;
    assign timer_interrupt    = timer_q;
    assign software_interrupt = msip_q;
    assign external_interrupt = ext_pend_q;

endmodule
